// File: rtl/seq_alu.sv
// Multi-cycle 16-bit ALU stage: single-cycle EXEC ops, iterative shift-add multiply.
// Define SEQ_ALU_DIV_EN to make op 111 an iterative unsigned divide instead of NOT a.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd3;
`endif

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_X7   = 3'b111;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] prod;
  logic               last;

  assign last = (cnt == CW'(WIDTH-1));

  // one multiplier bit (b_q) per edge, LSB first
  logic [2*WIDTH-1:0] mul_add;
  logic [2*WIDTH-1:0] prod_nx;

  assign mul_add = {{WIDTH{1'b0}}, a_q} << cnt;
  assign prod_nx = b_q[cnt] ? prod + mul_add : prod;

  logic [WIDTH-1:0] ex_res;
  logic             ex_ovf;

  always_comb begin
    ex_res = '0;
    ex_ovf = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        ex_res = a_q + b_q;
        ex_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                 (ex_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        ex_res = a_q - b_q;
        ex_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                 (ex_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_PASS: ex_res = a_q;
      OP_AND:  ex_res = a_q & b_q;
      OP_OR:   ex_res = a_q | b_q;
      OP_XOR:  ex_res = a_q ^ b_q;
      OP_X7:   ex_res = ~a_q;
      default: ex_res = '0;
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  // restoring divide: a_q shifts out dividend bits and shifts in quotient bits
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  assign rem_sh  = {rem, a_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign q_bit   = ~rem_sub[WIDTH];
  assign rem_nx  = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx  = {a_q[WIDTH-2:0], q_bit};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod     <= '0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      rem      <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            cnt  <= '0;
            prod <= '0;
            busy <= 1'b1;
`ifdef SEQ_ALU_DIV_EN
            rem  <= '0;
`endif
            if (op == OP_MUL) state <= S_MUL;
`ifdef SEQ_ALU_DIV_EN
            else if (op == OP_X7) state <= S_DIV;
`endif
            else state <= S_EXEC;
          end
        end
        S_EXEC: begin
          result   <= ex_res;
          overflow <= ex_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        S_MUL: begin
          prod <= prod_nx;
          cnt  <= cnt + CW'(1);
          if (last) begin
            result   <= prod_nx[WIDTH-1:0];
            overflow <= |prod_nx[2*WIDTH-1:WIDTH];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        S_DIV: begin
          rem <= rem_nx;
          a_q <= quo_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            result   <= quo_nx;
            overflow <= (b_q == '0);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
